// File: rtl/cpu_div_pkg.sv
// Shared definitions for the sequential integer divider: FSM states and sizing.
package cpu_div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, compare, subtract.
module div_step
   import cpu_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_nxt,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;

   // Compare at WIDTH+1 bits so a carried-out remainder bit is never lost.
   always_comb begin
      shifted = {rem, bit_in};
      q_bit   = (shifted >= {1'b0, dvs});
      rem_nxt = q_bit ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div.sv
// Sequential restoring divider for MIPS div/divu (quotient to lo_out, remainder to hi_out).
// Optional DIV_ZERO_DETECT_EN: a zero divisor finishes in one cycle with div_zero set.
module div
   import cpu_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             div_signed,
   input  logic             div_control,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_end,
   output logic             div_zero
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] quot;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH-1:0] rem_step;
   logic             q_bit;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             zero_hit;

`ifdef DIV_ZERO_DETECT_EN
   assign zero_hit = (b_in == '0);
`else
   assign zero_hit = 1'b0;
`endif

   assign abs_a = (div_signed && a_in[WIDTH-1]) ? -a_in : a_in;
   assign abs_b = (div_signed && b_in[WIDTH-1]) ? -b_in : b_in;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .bit_in  (dvd[WIDTH-1]),
      .dvs     (dvs),
      .rem_nxt (rem_step),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (div_control && !zero_hit) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         rem      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         quot     <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
         div_end  <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         div_end  <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (div_control) begin
                  if (zero_hit) begin
                     div_end  <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     dvd    <= abs_a;
                     dvs    <= abs_b;
                     sign_q <= div_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                     sign_r <= div_signed & a_in[WIDTH-1];
                     rem    <= '0;
                     quot   <= '0;
                     cnt    <= '0;
                  end
               end
            end
            RUN: begin
               rem  <= rem_step;
               dvd  <= {dvd[WIDTH-2:0], 1'b0};
               quot <= {quot[WIDTH-2:0], q_bit};
               cnt  <= cnt + 1'b1;
            end
            FIX: begin
               lo_out  <= sign_q ? -quot : quot;
               hi_out  <= sign_r ? -rem : rem;
               div_end <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
